fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 143 ++++++++++++++
 tb/tb_fetch_unit.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch: PC register with BOOT/RUN/HALT sequencing and branch/jump target selection.
// Optional retired/taken performance counters are compiled in with FETCH_PERF_CNT_EN.
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] HALT_INSTR = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic [5:0]  opcode,
    input  logic        branch,
    input  logic        jump,
    input  logic        zero,
    input  logic        stall,
    output logic [31:0] imem_addr,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        instr_valid,
    output logic        halt
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] retired_cnt,
    output logic [31:0] taken_cnt
`endif
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t      state_reg;
    logic [31:0] pc_reg;
    logic        instr_valid_reg;
    logic        halt_reg;

    logic        taken;
    logic        is_halt_instr;
    logic        retire;
    logic [31:0] branch_offset;
    logic [31:0] jump_target;
    logic [31:0] pc_next;

    // Only the beq/bne selector bit of the opcode matters here.
    logic unused_opcode;
    assign unused_opcode = ^opcode[5:1];

    assign pc          = pc_reg;
    assign imem_addr   = pc_reg;
    assign pc_plus4    = pc_reg + 32'd4;
    assign instr_valid = instr_valid_reg;
    assign halt        = halt_reg;

    // Word-aligned, sign-extended branch displacement built bit by bit.
    genvar gi;
    generate
        for (gi = 0; gi < 32; gi++) begin : g_offset
            if (gi < 2) begin : g_low
                assign branch_offset[gi] = 1'b0;
            end else if (gi < 18) begin : g_imm
                assign branch_offset[gi] = instr[gi-2];
            end else begin : g_sign
                assign branch_offset[gi] = instr[15];
            end
        end
    endgenerate

    assign taken         = branch && (opcode[0] ? !zero : zero);
    assign jump_target   = {pc_plus4[31:28], instr[25:0], 2'b00};
    assign is_halt_instr = (instr == HALT_INSTR);
    assign retire        = (state_reg == RUN) && !stall && !is_halt_instr;

    always_comb begin
        pc_next = pc_plus4;
        if (jump) begin
            pc_next = jump_target;
        end else if (taken) begin
            pc_next = pc_plus4 + branch_offset;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= BOOT;
            pc_reg          <= RESET_PC;
            instr_valid_reg <= 1'b0;
            halt_reg        <= 1'b0;
        end else begin
            case (state_reg)
                BOOT: begin
                    state_reg       <= RUN;
                    instr_valid_reg <= 1'b1;
                end
                RUN: begin
                    if (!stall) begin
                        if (is_halt_instr) begin
                            // pc stays on the halt instruction address
                            state_reg       <= HALT;
                            instr_valid_reg <= 1'b0;
                            halt_reg        <= 1'b1;
                        end else begin
                            pc_reg <= pc_next;
                        end
                    end
                end
                HALT: begin
                    state_reg <= HALT;
                end
                default: begin
                    state_reg       <= BOOT;
                    instr_valid_reg <= 1'b0;
                    halt_reg        <= 1'b0;
                end
            endcase
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] retired_cnt_reg;
    logic [31:0] taken_cnt_reg;

    assign retired_cnt = retired_cnt_reg;
    assign taken_cnt   = taken_cnt_reg;

    // Jumps are not counted as taken branches even when branch is also asserted.
    always_ff @(posedge clk) begin
        if (rst) begin
            retired_cnt_reg <= 32'd0;
            taken_cnt_reg   <= 32'd0;
        end else if (retire) begin
            retired_cnt_reg <= retired_cnt_reg + 32'd1;
            if (taken && !jump) begin
                taken_cnt_reg <= taken_cnt_reg + 32'd1;
            end
        end
    end
`else
    logic unused_retire;
    assign unused_retire = retire;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a spec-level PC model checked every cycle, plus literal pins.
module tb_fetch_unit;

    localparam logic [31:0] HALT_W  = 32'hFFFF_FFFF;
    localparam logic [31:0] NOP     = 32'h0000_0000;
    localparam logic [31:0] BEQ_M2  = {6'h04, 10'h000, 16'hFFFE};
    localparam logic [31:0] BNE_M2  = {6'h05, 10'h000, 16'hFFFE};
    localparam logic [31:0] BEQ_P2  = {6'h04, 10'h000, 16'h0002};
    localparam logic [31:0] BNE_P1  = {6'h05, 10'h000, 16'h0001};
    localparam logic [31:0] J_10    = {6'h02, 26'h000_0010};
    localparam logic [31:0] J_4     = {6'h02, 26'h000_0004};
    localparam logic [31:0] J_100   = {6'h02, 26'h000_0100};
    localparam logic [31:0] J_MAX   = {6'h02, 26'h3FF_FFFF};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] instr = 32'd0;
    logic [5:0]  opcode;
    logic        branch = 1'b0;
    logic        jump = 1'b0;
    logic        zero = 1'b0;
    logic        stall = 1'b0;
    logic [31:0] imem_addr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        instr_valid;
    logic        halt;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] retired_cnt;
    logic [31:0] taken_cnt;
`endif

    assign opcode = instr[31:26];

    fetch_unit dut (
        .clk        (clk),
        .rst        (rst),
        .instr      (instr),
        .opcode     (opcode),
        .branch     (branch),
        .jump       (jump),
        .zero       (zero),
        .stall      (stall),
        .imem_addr  (imem_addr),
        .pc         (pc),
        .pc_plus4   (pc_plus4),
        .instr_valid(instr_valid),
        .halt       (halt)
`ifdef FETCH_PERF_CNT_EN
        ,
        .retired_cnt(retired_cnt),
        .taken_cnt  (taken_cnt)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
        end
    endtask

    // Reference model: what the fetch unit must hold after each edge.
    bit          m_started = 1'b0;
    bit          m_booting = 1'b0;
    bit          m_halted  = 1'b0;
    logic [31:0] m_pc  = 32'd0;
    logic [31:0] m_ret = 32'd0;
    logic [31:0] m_tak = 32'd0;

    always @(posedge clk) begin
        logic [31:0] p4;
        logic [31:0] nxt;
        bit          tk;
        if (rst) begin
            m_started = 1'b1;
            m_booting = 1'b1;
            m_halted  = 1'b0;
            m_pc      = 32'h0000_0000;
            m_ret     = 32'd0;
            m_tak     = 32'd0;
        end else if (!m_started) begin
            m_pc = m_pc;
        end else if (m_booting) begin
            m_booting = 1'b0;
        end else if (!m_halted && !stall) begin
            if (instr == HALT_W) begin
                m_halted = 1'b1;
            end else begin
                p4 = m_pc + 32'd4;
                tk = branch && (opcode[0] ? !zero : zero);
                if (jump)    nxt = {p4[31:28], instr[25:0], 2'b00};
                else if (tk) nxt = p4 + {{14{instr[15]}}, instr[15:0], 2'b00};
                else         nxt = p4;
                m_pc  = nxt;
                m_ret = m_ret + 32'd1;
                if (tk && !jump) m_tak = m_tak + 32'd1;
            end
        end
    end

    always @(negedge clk) begin
        if (m_started) begin
            chk("pc", pc, m_pc);
            chk("imem_addr", imem_addr, m_pc);
            chk("pc_plus4", pc_plus4, m_pc + 32'd4);
            chk("instr_valid", 32'(instr_valid), 32'(!m_booting && !m_halted));
            chk("halt", 32'(halt), 32'(m_halted));
`ifdef FETCH_PERF_CNT_EN
            chk("retired_cnt", retired_cnt, m_ret);
            chk("taken_cnt", taken_cnt, m_tak);
`endif
        end
    end

    task automatic step(input logic [31:0] i, input logic br, input logic jp,
                        input logic z, input logic st);
        @(negedge clk);
        instr  = i;
        branch = br;
        jump   = jp;
        zero   = z;
        stall  = st;
        $display("step t=%0t pc=%h instr=%h br=%0b jp=%0b z=%0b st=%0b valid=%0b halt=%0b",
                 $time, pc, i, br, jp, z, st, instr_valid, halt);
    endtask

    // Reset is applied with conflicting inputs to show it overrides them.
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; stall = 1'b1; jump = 1'b1; branch = 1'b1; instr = J_100;
        @(negedge clk);
        rst = 1'b0; stall = 1'b0; jump = 1'b0; branch = 1'b0; instr = NOP; zero = 1'b0;
        $display("reset released t=%0t pc=%h", $time, pc);
        chk("rst_pc", pc, 32'h0000_0000);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_halt", 32'(halt), 32'd0);
`ifdef FETCH_PERF_CNT_EN
        chk("rst_retired", retired_cnt, 32'd0);
        chk("rst_taken", taken_cnt, 32'd0);
`endif
    endtask

    initial begin
        // Sequential fetch into a halt instruction at 0x18.
        do_reset();
        step(NOP, 0, 0, 0, 0);  chk("boot_run_pc", pc, 32'h0);
        chk("valid_rise", 32'(instr_valid), 32'd1);
        step(NOP, 0, 0, 0, 0);  chk("seq_pc4", pc, 32'h4);
        step(NOP, 0, 0, 0, 0);  chk("seq_pc8", pc, 32'h8);
        step(NOP, 0, 0, 0, 0);
        step(NOP, 0, 0, 0, 0);
        step(NOP, 0, 0, 0, 0);
        step(HALT_W, 0, 0, 0, 0); chk("halt_addr", pc, 32'h18);
        step(J_100, 1, 1, 1, 0);  chk("halt_set", 32'(halt), 32'd1);
        chk("halt_pc", pc, 32'h18);
        chk("halt_invalid", 32'(instr_valid), 32'd0);
        step(NOP, 0, 0, 0, 0);    chk("halt_sticky", pc, 32'h18);

        // Reset out of HALT, then stall at 0x20.
        do_reset();
        for (int k = 0; k < 8; k++) step(NOP, 0, 0, 0, 0);
        step(J_10, 1, 1, 1, 1);   chk("stall_pc0", pc, 32'h20);
`ifdef FETCH_PERF_CNT_EN
        chk("stall_retired", retired_cnt, 32'd8);
`endif
        step(J_10, 1, 1, 1, 1);   chk("stall_pc1", pc, 32'h20);
        step(J_10, 1, 1, 1, 1);   chk("stall_pc2", pc, 32'h20);
        step(NOP, 0, 0, 0, 0);    chk("stall_pc3", pc, 32'h20);
`ifdef FETCH_PERF_CNT_EN
        chk("stall_retired_held", retired_cnt, 32'd8);
`endif
        step(J_10, 0, 1, 0, 0);   chk("unstall_pc", pc, 32'h24);

        // beq/bne at 0x40 with a -8 byte displacement.
        step(BEQ_M2, 1, 0, 1, 0); chk("jump_to_40", pc, 32'h40);
        step(NOP, 0, 0, 0, 0);    chk("beq_taken", pc, 32'h3C);
        step(BEQ_M2, 1, 0, 0, 0); chk("back_40", pc, 32'h40);
        step(J_10, 0, 1, 0, 0);   chk("beq_not_taken", pc, 32'h44);
        step(BNE_M2, 1, 0, 0, 0); chk("back_40b", pc, 32'h40);
        step(NOP, 0, 0, 0, 0);    chk("bne_taken", pc, 32'h3C);
        step(BNE_M2, 1, 0, 1, 0); chk("back_40c", pc, 32'h40);
        step(J_MAX, 0, 1, 0, 0);  chk("bne_not_taken", pc, 32'h44);

        // Jump region handling and jump-over-branch priority.
        step(J_4, 0, 1, 0, 0);    chk("jmp_0fff", pc, 32'h0FFF_FFFC);
        step(J_100, 0, 1, 0, 0);  chk("jmp_region1", pc, 32'h1000_0010);
        step(J_4, 0, 1, 0, 0);    chk("jmp_400", pc, 32'h1000_0400);
        step(J_100, 1, 1, 1, 0);  chk("jmp_back", pc, 32'h1000_0010);
        step(J_MAX, 0, 1, 0, 0);  chk("jmp_beats_branch", pc, 32'h1000_0400);

        // Climb one 256MB region per jump up to the top of the address space.
        for (int k = 1; k <= 14; k++) step(J_MAX, 0, 1, 0, 0);
        step(NOP, 0, 0, 0, 0);    chk("pc_top", pc, 32'hFFFF_FFFC);
        step(NOP, 0, 0, 0, 0);    chk("pc_wrap", pc, 32'h0000_0000);
        chk("pc_plus4_wrap_src", pc_plus4, 32'h0000_0004);

        // Five retirements: two taken branches, one jump, two plain.
        do_reset();
        step(BEQ_P2, 1, 0, 1, 0); chk("cnt_pc0", pc, 32'h0);
        step(BNE_P1, 1, 0, 0, 0); chk("cnt_beq", pc, 32'hC);
        step(J_10, 0, 1, 0, 0);   chk("cnt_bne", pc, 32'h14);
        step(NOP, 0, 0, 0, 0);    chk("cnt_jmp", pc, 32'h40);
        step(NOP, 0, 0, 0, 0);    chk("cnt_seq", pc, 32'h44);
        step(NOP, 0, 0, 0, 1);    chk("cnt_last", pc, 32'h48);
`ifdef FETCH_PERF_CNT_EN
        chk("retired_5", retired_cnt, 32'd5);
        chk("taken_2", taken_cnt, 32'd2);
`endif
        step(NOP, 0, 0, 0, 0);    chk("cnt_stall_hold", pc, 32'h48);
        step(NOP, 0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
